edge_detector_array: RTL

EDGE_DETECTOR_ARRAY -- requirements
Module: edge_detector_array

---
 rtl/edge_detector_array.sv | 113 +++++++++++
 1 files changed

// File: rtl/edge_detector_array.sv
// Per-channel edge detector with stretched, retriggerable pulses and
// saturating per-channel event counters. One channel instance per input bit.

module edge_detector_chan #(
   parameter int PULSE_LEN = 1,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_bit,
   input  logic [1:0]       mode,
   input  logic             clr,
   output logic             pulse,
   output logic [CNT_W-1:0] count
);

   localparam int PW = $clog2(PULSE_LEN + 1);

   // ARM waits for the first sample; LOW/HIGH hold the stored level.
   // The PULSE(k) part of the state lives in plen_q (remaining pulse cycles).
   typedef enum logic [1:0] {ST_ARM, ST_LOW, ST_HIGH} state_t;

   state_t           state_q, state_d;
   logic [PW-1:0]    plen_q, plen_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             qual;

   // Next-state: level tracking, edge qualification, pulse timer, counter
   always_comb begin
      state_d = state_q;
      plen_d  = plen_q;
      cnt_d   = cnt_q;
      qual    = 1'b0;
      case (state_q)
         ST_ARM:  state_d = in_bit ? ST_HIGH : ST_LOW;
         ST_LOW: begin
            qual = in_bit && (mode == 2'b00 || mode == 2'b10);
            if (in_bit) state_d = ST_HIGH;
         end
         ST_HIGH: begin
            qual = !in_bit && (mode == 2'b01 || mode == 2'b10);
            if (!in_bit) state_d = ST_LOW;
         end
         default: state_d = ST_ARM;
      endcase
      // a qualified edge (re)loads the full pulse length, otherwise count down
      if (qual)
         plen_d = PW'(PULSE_LEN);
      else if (plen_q != '0)
         plen_d = plen_q - PW'(1);
      // clear wins over a simultaneous event; counter saturates at all-ones
      if (clr)
         cnt_d = '0;
      else if (qual && cnt_q != '1)
         cnt_d = cnt_q + CNT_W'(1);
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_ARM;
         plen_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         plen_q  <= plen_d;
         cnt_q   <= cnt_d;
      end
   end

   assign pulse = (plen_q != '0);
   assign count = cnt_q;

endmodule

module edge_detector_array #(
   parameter int WIDTH     = 4,
   parameter int PULSE_LEN = 1,
   parameter int CNT_W     = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [WIDTH-1:0]       in,
   input  logic [1:0]             mode,
   input  logic                   clr,
   output logic [WIDTH-1:0]       pulse,
   output logic                   any_pulse,
   output logic [WIDTH*CNT_W-1:0] count
);

   logic [WIDTH-1:0][CNT_W-1:0] cnt_arr;

   for (genvar g = 0; g < WIDTH; g++) begin : g_chan
      edge_detector_chan #(
         .PULSE_LEN (PULSE_LEN),
         .CNT_W     (CNT_W)
      ) u_chan (
         .clk    (clk),
         .rst    (rst),
         .in_bit (in[g]),
         .mode   (mode),
         .clr    (clr),
         .pulse  (pulse[g]),
         .count  (cnt_arr[g])
      );
   end

   assign count = cnt_arr;

   // pulse bits are registered, so the OR is glitch-free relative to clk
   assign any_pulse = |pulse;

endmodule
